// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the asynchronous FIFO write- and read-side controllers.
//
// Contents:
//   log2()        - ceiling log2, used to derive pointer widths from DEPTH
//   bin_to_gray() - binary to reflected Gray code (up to 32 bits)
//   gray_to_bin() - reflected Gray code to binary (up to 32 bits)
//   wr_flags_t    - registered status flags of the write side
//
// Callers zero-extend their operands to 32 bits and cast the result back to
// their own width. Zero upper bits do not disturb the lower bits of either
// conversion, so one fixed-width implementation serves every pointer width.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FN_W = 32;

    typedef struct packed {
        logic full;
        logic almost_full;
    } wr_flags_t;

    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [FN_W-1:0] bin_to_gray(input logic [FN_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [FN_W-1:0] gray_to_bin(input logic [FN_W-1:0] gray);
        logic [FN_W-1:0] bin;
        bin[FN_W-1] = gray[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Purely combinational Gray-to-binary converter.
//
// Parameters:
//   W    - pointer width (at most 32)
// Ports:
//   gray - input,  W bits: Gray-coded value
//   bin  - output, W bits: binary equivalent
// -----------------------------------------------------------------------------
module gray2bin
    import fifo_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    assign bin = W'(gray_to_bin(FN_W'(gray)));

endmodule

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side controller of an asynchronous FIFO. Keeps the binary and Gray
// write pointers, generates the memory write strobe/address and derives the
// full, almost-full and occupancy flags against the read pointer that has
// already been synchronised into wclk.
//
// Parameters:
//   DEPTH        - number of FIFO entries (power of two, >= 4)
//   AFULL_TH     - occupancy at or above which walmost_full asserts (1..DEPTH)
// Ports:
//   wclk         - in : write clock, rising edge
//   wrst         - in : asynchronous reset, active-low
//   winc         - in : write request
//   rptr         - in : AW+1 bits, Gray read pointer synchronised to wclk
//   wen          - out: memory write strobe (winc & ~wfull)
//   waddr        - out: AW bits, memory write address
//   wptr         - out: AW+1 bits, registered Gray write pointer
//   wfull        - out: registered full flag
//   walmost_full - out: registered almost-full flag
//   wlevel       - out: AW+1 bits, registered occupancy (0..DEPTH)
//   wovf         - out: sticky overflow flag
//
// Build option:
//   FIFO_WR_OVF_EN - when defined, wovf is a sticky flop set by a write
//                    attempted while full; otherwise wovf is constant 0.
// -----------------------------------------------------------------------------
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter  int DEPTH    = 8,
    parameter  int AFULL_TH = DEPTH - 2,
    localparam int AW       = log2(DEPTH)
) (
    input  logic          wclk,
    input  logic          wrst,
    input  logic          winc,
    input  logic [AW:0]   rptr,
    output logic          wen,
    output logic [AW-1:0] waddr,
    output logic [AW:0]   wptr,
    output logic          wfull,
    output logic          walmost_full,
    output logic [AW:0]   wlevel,
    output logic          wovf
);

    localparam int        PW    = AW + 1;
    localparam logic [AW:0] AF_TH = PW'(AFULL_TH);

    logic [AW:0] wbin;
    logic [AW:0] wbin_next;
    logic [AW:0] wgray_next;
    logic [AW:0] rbin;
    logic [AW:0] full_cmp;
    logic [AW:0] level_next;
    logic        accept;
    wr_flags_t   flags;
    wr_flags_t   flags_next;

    gray2bin #(
        .W (PW)
    ) u_rptr_g2b (
        .gray (rptr),
        .bin  (rbin)
    );

    assign accept     = winc & ~wfull;
    assign wen        = accept;
    assign waddr      = wbin[AW-1:0];

    assign wbin_next  = wbin + PW'(accept);
    assign wgray_next = PW'(bin_to_gray(FN_W'(wbin_next)));

    // The writer is exactly one lap (DEPTH entries) ahead of the reader when
    // the two top Gray bits differ and the remainder matches.
    assign full_cmp   = {~rptr[AW], ~rptr[AW-1], rptr[AW-2:0]};
    assign level_next = wbin_next - rbin;

    always_comb begin
        flags_next             = '0;
        flags_next.full        = (wgray_next == full_cmp);
        flags_next.almost_full = (level_next >= AF_TH);
    end

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            wbin   <= '0;
            wptr   <= '0;
            wlevel <= '0;
            flags  <= '0;
        end else begin
            wbin   <= wbin_next;
            wptr   <= wgray_next;
            wlevel <= level_next;
            flags  <= flags_next;
        end
    end

    assign wfull        = flags.full;
    assign walmost_full = flags.almost_full;

`ifdef FIFO_WR_OVF_EN
    logic ovf;

    // Sticky: only reset clears it.
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            ovf <= 1'b0;
        end else if (winc && wfull) begin
            ovf <= 1'b1;
        end
    end

    assign wovf = ovf;
`else
    assign wovf = 1'b0;
`endif

endmodule
